wb_master_arbiter: RTL and testbench
====================================

# wb_master_arbiter

Two-master Wishbone B4 classic arbiter. It shares the single master port of the `wb_intercon` slave-side fabric between the processor data port (`wishbone_controller`, master 0) and a second bus master, master 1 (boot loader copy engine or debug port). It grants with round-robin fairness and holds the grant for a whole `cyc` period. An optional watchdog terminates stalled transfers with an error.

## Interface

**Parameters**
- `AW`, 32: address width.
- `DW`, 32: data width; `sel` width is `DW/8`.
- `TIMEOUT`, 255: cycles a strobe may wait for `ack`/`err` before forced termination. Must be 1..65535.

**Ports**
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `m0_adr_i` in AW, `m0_dat_i` in DW, `m0_sel_i` in DW/8, `m0_we_i` in 1, `m0_cyc_i` in 1, `m0_stb_i` in 1: master 0 request.
- `m0_dat_o` out DW, `m0_ack_o` out 1, `m0_err_o` out 1: master 0 response.
- `m1_*`: identical set for master 1.
- `s_adr_o` out AW, `s_dat_o` out DW, `s_sel_o` out DW/8, `s_we_o` out 1, `s_cyc_o` out 1, `s_stb_o` out 1: toward interconnect.
- `s_dat_i` in DW, `s_ack_i` in 1, `s_err_i` in 1: from interconnect.
- `grant_o` out 2: one-hot current owner; 00 when idle.
- `timeout_o` out 1: one-cycle pulse on watchdog termination.

## Operation

- FSM states: IDLE, OWN0, OWN1. Reset → IDLE. `last` pointer resets to 1, so master 0 wins the first tie.
- IDLE:
  - If only one `mN_cyc_i` is high → OWNN.
  - If both are high → own the master that is not `last`.
  - If neither → stay.
- OWNN:
  - Slave outputs are a combinational mux of master N's signals.
  - `s_cyc_o = mN_cyc_i`, `s_stb_o = mN_stb_i & mN_cyc_i`.
  - The grant is held while `mN_cyc_i` is high, including multiple back-to-back strobes; there is no preemption.
  - On `mN_cyc_i` low: `last <= N`. Go to OWN(other) if the other `cyc` is high, else IDLE. Handoff costs exactly one cycle with `s_cyc_o` low.
- Response routing:
  - `m0_dat_o = m1_dat_o = s_dat_i`.
  - `mN_ack_o = s_ack_i & ownN`, `mN_err_o = s_err_i & ownN`.
  - The non-owner's ack and err are always 0.
- In IDLE, all `s_*` outputs are 0 and no ack/err reaches either master.
- Reset asserted mid-transfer: FSM goes to IDLE immediately (asynchronously). All outputs go low; watchdog counter clears.

## Timing

- Reset values: `s_cyc_o`, `s_stb_o`, `s_we_o` = 0; `s_adr_o`, `s_dat_o`, `s_sel_o` = 0; all `mN_ack_o`/`mN_err_o` = 0; `grant_o` = 00; `timeout_o` = 0.
- Arbitration latency: `cyc`/`stb` asserted in cycle T from IDLE → `s_cyc_o`/`s_stb_o` high in T+1.
- Once owned, `ack`/`err` are passed through combinationally in the same cycle.
- A single read completes at the earliest at T+1 when the slave acks combinationally.
- `grant_o` is registered and reflects the FSM state.

## Configuration

`WB_ARB_TIMEOUT_EN`

**Defined:**
- A 16-bit counter clears on IDLE, on any grant change, and on any cycle with `s_ack_i | s_err_i`.
- It increments each cycle that `s_stb_o` is high without a response.
- When the counter equals `TIMEOUT`, in that same cycle:
  - `mN_err_o` is forced to 1 for the owner.
  - `s_stb_o` is forced to 0.
  - `timeout_o` pulses.
  - The counter clears.
- The grant remains until the owner drops `cyc`.
- If `s_ack_i` arrives in the same cycle the counter hits `TIMEOUT`, `ack` wins and no error is generated.

**Undefined:** no counter; `timeout_o` is tied to 0; a hung slave stalls the owner indefinitely.

## Test plan

- **Reset and single master:** reset held, then `m0` read to 0x0000_1000; slave acks with 0xDEADBEEF after 2 cycles. Required: `s_stb_o` rises 1 cycle after `m0_stb_i`; `m0_ack_o` and `m0_dat_o` = 0xDEADBEEF; `m1_ack_o` stays 0.
- **Simultaneous request after reset:** `m0` and `m1` raise `cyc` in the same cycle. Required: `grant_o` = 01 first. After `m0` drops `cyc`, one idle cycle, then `grant_o` = 10.
- **Fairness:** both masters continuously re-request 4 single transfers each. Required: grants alternate 0,1,0,1…; neither master is granted twice in a row.
- **Burst hold:** `m1` owns and issues 3 back-to-back writes (`sel` = 4'b1111) with `cyc` held high while `m0` requests. Required: all 3 reach the slave before `grant_o` changes to 01.
- **Watchdog (`WB_ARB_TIMEOUT_EN`, `TIMEOUT` = 8):** slave never acks. Required: `m0_err_o` and `timeout_o` pulse exactly 8 cycles after `s_stb_o` rises. Variant: ack arrives on cycle 8, producing ack and no err.
- **Reset mid-transfer:** pull `reset_n` low while `m1` owns with `stb` high. Required: `s_cyc_o` = 0 and `grant_o` = 00 without waiting for a clock edge. After release, `m0` wins a tie.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
//
// Two-master Wishbone B4 classic arbiter. Shares the single master port of the
// wb_intercon fabric between master 0 (processor data port) and master 1
// (boot-loader copy engine or debug port). Arbitration is round-robin between
// the two masters. A grant lasts for the owner's whole cyc period and is never
// preempted.
//
// Optional feature (compile-time macro WB_ARB_TIMEOUT_EN):
//   When defined, a 16-bit watchdog terminates a strobe that has waited
//   TIMEOUT cycles without ack/err. The owner gets an error and timeout_o
//   pulses. When undefined, there is no watchdog and timeout_o is tied low.
//
// Parameters
//   AW       address width
//   DW       data width (sel width is DW/8)
//   TIMEOUT  watchdog limit in cycles, 1..65535
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   m0_*_i / m0_*_o               master 0 request / response
//   m1_*_i / m1_*_o               master 1 request / response
//   s_*_o / s_*_i                 shared port toward the interconnect
//   grant_o                       registered one-hot owner, 00 when idle
//   timeout_o                     one-cycle pulse on watchdog termination
//   dbg_state                     current FSM state (IDLE=0, OWN0=1, OWN1=2)
//
// Handshake: a transfer is requested while cyc and stb are both high (the
// "valid" side). It completes in any cycle where the slave returns ack or err
// (the "ready" side). Request signals must stay stable until then. A response
// is forwarded only to the master that currently owns the bus.
// ---------------------------------------------------------------------------
module wb_master_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,

  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,

  output logic [1:0]      grant_o,
  output logic            timeout_o,
  output logic [1:0]      dbg_state
);

  // A watchdog limit outside the counter range is a configuration error.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_master_arbiter: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  logic   last;      // master that most recently released the bus
  logic   own0;
  logic   own1;
  logic   stb_raw;   // owner's strobe before watchdog masking
  logic   wd_fire;   // watchdog terminates the current strobe this cycle

  assign own0      = (state == OWN0);
  assign own1      = (state == OWN1);
  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Arbitration FSM. grant_o is registered alongside the state so it always
  // matches the owner. On a tie the master that did not release last wins.
  // A handoff passes through the cycle in which the old owner's cyc is low,
  // so the shared port always sees exactly one cycle with cyc low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      grant_o <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            if (last) begin
              state   <= OWN0;
              grant_o <= 2'b01;
            end else begin
              state   <= OWN1;
              grant_o <= 2'b10;
            end
          end else if (m0_cyc_i) begin
            state   <= OWN0;
            grant_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state   <= OWN1;
            grant_o <= 2'b10;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            last <= 1'b0;
            if (m1_cyc_i) begin
              state   <= OWN1;
              grant_o <= 2'b10;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            last <= 1'b1;
            if (m0_cyc_i) begin
              state   <= OWN0;
              grant_o <= 2'b01;
            end else begin
              state   <= IDLE;
              grant_o <= 2'b00;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Request mux toward the interconnect. It is driven purely from the
  // registered owner, so reset silences the shared port without a clock.
  // -------------------------------------------------------------------------
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      stb_raw = m0_stb_i & m0_cyc_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      stb_raw = m1_stb_i & m1_cyc_i;
    end
  end

  // The watchdog withdraws the strobe in the cycle it substitutes the error,
  // so the slave never sees a request that no master will complete.
  assign s_stb_o = stb_raw & ~wd_fire;

  // Response routing: data fans out to both masters; handshakes go only to
  // the owner.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & own0;
  assign m1_ack_o = s_ack_i & own1;
  assign m0_err_o = own0 & (s_err_i | wd_fire);
  assign m1_err_o = own1 & (s_err_i | wd_fire);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  logic [15:0] wd_cnt;
  logic        releasing;

  // Owner dropping cyc means the grant changes (to IDLE or the other master)
  // on the next edge, so the count restarts for the next owner.
  assign releasing = (own0 & ~m0_cyc_i) | (own1 & ~m1_cyc_i);

  // A real response in the limit cycle wins over the watchdog.
  assign wd_fire   = stb_raw & ~s_ack_i & ~s_err_i & (wd_cnt == WD_LIMIT);
  assign timeout_o = wd_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if ((state == IDLE) || releasing || s_ack_i || s_err_i || wd_fire) begin
      wd_cnt <= '0;
    end else if (stb_raw) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_master_arbiter
//
// Bench for wb_master_arbiter (AW=DW=32, TIMEOUT=8). Two master driver tasks,
// a latency-configurable slave responder and a monitor that pops expected
// slave-side transfers {grant, we, adr, dat, sel} from exp_q on every
// completed transfer. The order of the pushed records encodes the expected
// arbitration order. Define WB_ARB_TIMEOUT_EN to build with the watchdog.
// ---------------------------------------------------------------------------
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        m_cyc[2];
  logic        m_stb[2];
  logic        m_we[2];
  logic [31:0] m_adr[2];
  logic [31:0] m_dat[2];
  logic [3:0]  m_sel[2];

  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [1:0]  grant_o, dbg_state;
  logic        timeout_o;

  logic [70:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  int          slv_lat = 2;
  bit          slv_err = 1'b0;
  int          wcnt    = 0;

  wb_master_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / global bound ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_time_bound: simulation did not finish in time");
    $fatal(1, "time bound expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'hC3C3_3C3C);
  endfunction

  function automatic logic [70:0] rec(input int m, input bit we, input logic [31:0] adr,
                                      input logic [31:0] dat, input logic [3:0] sel);
    logic [1:0] g;
    g = (m == 0) ? 2'b01 : 2'b10;
    return {g, we, adr, (we ? dat : 32'h0), sel};
  endfunction

  function automatic logic m_ack(input int m);
    return (m == 0) ? m0_ack_o : m1_ack_o;
  endfunction

  function automatic logic m_err(input int m);
    return (m == 0) ? m0_err_o : m1_err_o;
  endfunction

  function automatic logic [31:0] m_rdat(input int m);
    return (m == 0) ? m0_dat_o : m1_dat_o;
  endfunction

  // ---------------- slave model ----------------
  // Registered slave: counts cycles of pending strobe and answers in the
  // cycle after slv_lat strobe cycles have been seen.
  assign s_dat_i = rd_fn(s_adr_o);

  initial begin
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (s_cyc_o && s_stb_o && !s_ack_i && !s_err_i) wcnt++;
      else wcnt = 0;
      @(posedge clk); #2;
      s_ack_i = (wcnt == slv_lat) && !slv_err;
      s_err_i = (wcnt == slv_lat) && slv_err;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("nonowner_resp",
            {((m0_ack_o | m0_err_o) & ~grant_o[0]), ((m1_ack_o | m1_err_o) & ~grant_o[1]), &grant_o},
            3'b000);
      if (s_cyc_o && s_stb_o && (s_ack_i || s_err_i)) begin
        if (exp_q.size() == 0) check("exp_q_underflow", exp_q.size(), 1);
        else check("slave_xfer", {grant_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_masters();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
      m_adr[m] = '0;   m_dat[m] = '0;   m_sel[m] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_masters();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One single transfer; waits (bounded) for ack/err, then drops stb and,
  // unless keep is set, cyc.
  task automatic xfer(input int m, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit keep, output bit got_err);
    int n;
    bit done;
    @(posedge clk); #1;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr;  m_dat[m] = we ? dat : 32'h0; m_sel[m] = sel;
    n = 0; done = 1'b0; got_err = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (m_ack(m) || m_err(m)) begin
        done    = 1'b1;
        got_err = m_err(m);
        if (!we && m_ack(m)) check($sformatf("rdata_m%0d", m), m_rdat(m), rd_fn(adr));
      end else begin
        n++;
        if (n > 200) begin
          check($sformatf("xfer_bound_m%0d", m), n, 200);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    m_stb[m] = 1'b0;
    if (!keep) m_cyc[m] = 1'b0;
  endtask

  // Master 0 read with a slave of latency lat; returns the cycle index (0 =
  // first cycle the shared cyc is up) of err, ack and timeout_o.
  task automatic wd_probe(input int lat, output int err_at, output int ack_at,
                          output int to_at, output logic stb_at_err);
    int idx;
    slv_lat = lat;
    err_at = -1; ack_at = -1; to_at = -1; stb_at_err = 1'b1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
    m_adr[0] = 32'h0000_2000; m_dat[0] = '0; m_sel[0] = 4'hF;
    idx = -1;
    for (int c = 0; c < 60 && err_at < 0 && ack_at < 0; c++) begin
      @(negedge clk);
      if (idx >= 0 || s_cyc_o) idx++;
      if (timeout_o && to_at < 0) to_at = idx;
      if (m0_err_o) begin err_at = idx; stb_at_err = s_stb_o; end
      if (m0_ack_o) ack_at = idx;
    end
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    slv_lat = 2;
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] d0[4], d1[4];
  logic [3:0]  q0[4], q1[4];
  bit          e0, e1;
  int          n, ea, aa, ta;
  logic        sa;

  initial begin
    reset_n = 1'b0;
    clear_masters();

    // Reset values and a single master-0 read
    repeat (3) @(negedge clk);
    check("rst_s_ctrl", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
    check("rst_s_bus", {s_adr_o, s_dat_o, s_sel_o}, 68'h0);
    check("rst_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0000);
    check("rst_grant", {grant_o, timeout_o, dbg_state}, 5'b00000);
    reset_n = 1'b1;

    exp_q.push_back(rec(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF));
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
    m_adr[0] = 32'h0000_1000; m_sel[0] = 4'hF;
    @(negedge clk);
    check("arb_lat_T", {s_cyc_o, s_stb_o}, 2'b00);
    @(negedge clk);
    check("arb_lat_T1", {s_cyc_o, s_stb_o, grant_o}, 4'b1101);
    n = 1;
    while (!m0_ack_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_latency", n, 3);
    check("rd_data_m0", m0_dat_o, 32'hDEAD_BEEF);
    check("m1_ack_quiet", m1_ack_o, 1'b0);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;

    // Simultaneous request after reset: master 0 first, one-cycle handoff
    do_reset();
    d0[0] = $urandom; d1[0] = $urandom;
    exp_q.push_back(rec(0, 1'b1, 32'h0000_0100, d0[0], 4'hF));
    exp_q.push_back(rec(1, 1'b1, 32'h0000_0200, d1[0], 4'hF));
    fork
      begin
        xfer(0, 1'b1, 32'h0000_0100, d0[0], 4'hF, 1'b0, e0);
        @(negedge clk);
        check("handoff_gap", {grant_o, s_cyc_o}, 3'b010);
        @(negedge clk);
        check("handoff_grant", {grant_o, s_cyc_o}, 3'b101);
      end
      xfer(1, 1'b1, 32'h0000_0200, d1[0], 4'hF, 1'b0, e1);
    join

    // Fairness: both masters keep re-requesting; grants must alternate
    for (int i = 0; i < 4; i++) begin
      d0[i] = $urandom; d1[i] = $urandom;
      q0[i] = 4'($urandom_range(1, 15)); q1[i] = 4'($urandom_range(1, 15));
      exp_q.push_back(rec(0, 1'b1, 32'h0000_3000 + 32'(i * 4), d0[i], q0[i]));
      exp_q.push_back(rec(1, 1'b1, 32'h0000_4000 + 32'(i * 4), d1[i], q1[i]));
    end
    fork
      for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'h0000_3000 + 32'(i * 4), d0[i], q0[i], 1'b0, e0);
      for (int i = 0; i < 4; i++) xfer(1, 1'b1, 32'h0000_4000 + 32'(i * 4), d1[i], q1[i], 1'b0, e1);
    join

    // Burst hold: master 1 keeps cyc across 3 writes while master 0 waits
    for (int i = 0; i < 3; i++) begin
      d1[i] = $urandom;
      exp_q.push_back(rec(1, 1'b1, 32'h0000_5000 + 32'(i * 4), d1[i], 4'hF));
    end
    d0[0] = $urandom;
    exp_q.push_back(rec(0, 1'b1, 32'h0000_6000, d0[0], 4'hF));
    fork
      begin
        xfer(1, 1'b1, 32'h0000_5000, d1[0], 4'hF, 1'b1, e1);
        xfer(1, 1'b1, 32'h0000_5004, d1[1], 4'hF, 1'b1, e1);
        xfer(1, 1'b1, 32'h0000_5008, d1[2], 4'hF, 1'b0, e1);
      end
      begin
        repeat (2) @(posedge clk);
        xfer(0, 1'b1, 32'h0000_6000, d0[0], 4'hF, 1'b0, e0);
      end
    join

    // Slave error routed to the owner only
    slv_err = 1'b1;
    exp_q.push_back(rec(1, 1'b0, 32'h0000_7000, 32'h0, 4'h3));
    xfer(1, 1'b0, 32'h0000_7000, 32'h0, 4'h3, 1'b0, e1);
    check("slave_err_m1", e1, 1'b1);
    slv_err = 1'b0;

    // Read data routing for master 1
    exp_q.push_back(rec(1, 1'b0, 32'h0000_7010, 32'h0, 4'hC));
    xfer(1, 1'b0, 32'h0000_7010, 32'h0, 4'hC, 1'b0, e1);
    check("read_ok_m1", e1, 1'b0);

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog with a hung slave
    wd_probe(100000, ea, aa, ta, sa);
    check("wd_err_cycle", ea, 8);
    check("wd_to_cycle", ta, 8);
    check("wd_stb_masked", sa, 1'b0);
    check("wd_no_ack", aa, -1);
    // Ack in the limit cycle wins
    exp_q.push_back(rec(0, 1'b0, 32'h0000_2000, 32'h0, 4'hF));
    wd_probe(8, ea, aa, ta, sa);
    check("wd_ack_wins", aa, 8);
    check("wd_ack_no_err", ea, -1);
    check("wd_ack_no_to", ta, -1);
`else
    // Without the watchdog a slow slave is simply waited for
    exp_q.push_back(rec(0, 1'b0, 32'h0000_2000, 32'h0, 4'hF));
    wd_probe(20, ea, aa, ta, sa);
    check("slow_ack_cycle", aa, 20);
    check("slow_no_err", ea, -1);
    check("slow_no_timeout", ta, -1);
`endif

    // Reset in the middle of a master-1 transfer
    slv_lat = 100000;
    @(posedge clk); #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1] = 32'h0000_8000; m_dat[1] = 32'h1234_5678; m_sel[1] = 4'hF;
    repeat (3) @(negedge clk);
    check("mid_owned", {grant_o, s_cyc_o, s_stb_o}, 4'b1011);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_bus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, 71'h0);
    check("async_rst_grant", {grant_o, dbg_state, timeout_o}, 5'b00000);
    clear_masters();
    slv_lat = 2;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Tie after reset: master 0 wins
    d0[0] = $urandom; d1[0] = $urandom;
    exp_q.push_back(rec(0, 1'b1, 32'h0000_9000, d0[0], 4'hA));
    exp_q.push_back(rec(1, 1'b1, 32'h0000_9100, d1[0], 4'h5));
    fork
      xfer(0, 1'b1, 32'h0000_9000, d0[0], 4'hA, 1'b0, e0);
      xfer(1, 1'b1, 32'h0000_9100, d1[0], 4'h5, 1'b0, e1);
    join

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("final_idle", {grant_o, s_cyc_o}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
